// File: rtl/spi_controller_pkg.sv
// Shared types and constants for the SPI memory sequencing controller.
package spi_pkg;

    localparam int unsigned SPI_WIDTH = 8;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        GET_ADDR    = 3'd1,
        DECIDE      = 3'd2,
        READ_LOAD   = 3'd3,
        READ_SHIFT  = 3'd4,
        WRITE_GET   = 3'd5,
        WRITE_STORE = 3'd6,
        DONE        = 3'd7
    } spi_state_t;

endpackage

// File: rtl/spi_controller_if.sv
// Control bundle between the input conditioners / datapath and the SPI controller.
// transferAborted exists only when SPI_CTRL_ABORT_FLAG_EN is defined.
interface spi_controller_if;

    logic chipSelect;
    logic peripheralClkEdge;
    logic rwBit;
    logic parallelLoad;
    logic addrWriteEnable;
    logic dmWriteEnable;
    logic misoBufferEnable;
`ifdef SPI_CTRL_ABORT_FLAG_EN
    logic transferAborted;
`endif

`ifdef SPI_CTRL_ABORT_FLAG_EN
    modport slave (
        input  chipSelect, peripheralClkEdge, rwBit,
        output parallelLoad, addrWriteEnable, dmWriteEnable, misoBufferEnable,
        output transferAborted
    );
    modport master (
        output chipSelect, peripheralClkEdge, rwBit,
        input  parallelLoad, addrWriteEnable, dmWriteEnable, misoBufferEnable,
        input  transferAborted
    );
`else
    modport slave (
        input  chipSelect, peripheralClkEdge, rwBit,
        output parallelLoad, addrWriteEnable, dmWriteEnable, misoBufferEnable
    );
    modport master (
        output chipSelect, peripheralClkEdge, rwBit,
        input  parallelLoad, addrWriteEnable, dmWriteEnable, misoBufferEnable
    );
`endif

endinterface

// File: rtl/spi_controller_bit_counter.sv
// Serial bit counter; o_done flags the pulse that completes a WIDTH-bit byte.
module spi_bit_counter
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH = SPI_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] r_count;

    // clear wins over increment so a finishing byte restarts at zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_done = (r_count == CNT_W'(WIDTH - 1)) && i_inc;

endmodule

// File: rtl/spi_controller.sv
// SPI memory sequencing controller: counts SCLK edge pulses during a
// chip-select window and issues the address-latch, parallel-load,
// data-memory write and MISO-enable strobes. All strobes are registered
// copies of the next-state decode, so they follow the state exactly.
// Optional feature: SPI_CTRL_ABORT_FLAG_EN adds the transferAborted pulse.
module spi_controller
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH = SPI_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    spi_controller_if.slave  bus
);

    spi_state_t r_state;
    spi_state_t w_next_state;

    logic w_counting;
    logic w_count_inc;
    logic w_count_clear;
    logic w_count_done;

    logic r_parallel_load;
    logic r_addr_we;
    logic r_dm_we;
    logic r_miso_en;
    logic w_parallel_load;
    logic w_addr_we;
    logic w_dm_we;
    logic w_miso_en;

    spi_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_count_clear),
        .i_inc   (w_count_inc),
        .o_done  (w_count_done)
    );

    // only the three shifting states accept edge pulses
    always_comb begin
        w_counting  = (r_state == GET_ADDR) || (r_state == READ_SHIFT) || (r_state == WRITE_GET);
        w_count_inc = w_counting && bus.peripheralClkEdge;
    end

    // next state, counter clear and next-cycle strobe decode
    always_comb begin
        w_next_state    = r_state;
        w_parallel_load = 1'b0;
        w_addr_we       = 1'b0;
        w_dm_we         = 1'b0;
        w_miso_en       = 1'b0;
        w_count_clear   = 1'b0;

        if (bus.chipSelect) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE:        w_next_state = GET_ADDR;
                GET_ADDR:    if (w_count_done) w_next_state = DECIDE;
                DECIDE:      w_next_state = (bus.rwBit == RW_READ) ? READ_LOAD : WRITE_GET;
                READ_LOAD:   w_next_state = READ_SHIFT;
                READ_SHIFT:  if (w_count_done) w_next_state = DONE;
                WRITE_GET:   if (w_count_done) w_next_state = WRITE_STORE;
                WRITE_STORE: w_next_state = DONE;
                DONE:        w_next_state = DONE;
                default:     w_next_state = IDLE;
            endcase
        end

        case (w_next_state)
            DECIDE:      w_addr_we       = 1'b1;
            READ_LOAD:   w_parallel_load = 1'b1;
            READ_SHIFT:  w_miso_en       = 1'b1;
            WRITE_STORE: w_dm_we         = 1'b1;
            default:     ;
        endcase

        w_count_clear = (w_next_state != r_state);
    end

    // state and registered strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_parallel_load <= 1'b0;
            r_addr_we       <= 1'b0;
            r_dm_we         <= 1'b0;
            r_miso_en       <= 1'b0;
        end else begin
            r_state         <= w_next_state;
            r_parallel_load <= w_parallel_load;
            r_addr_we       <= w_addr_we;
            r_dm_we         <= w_dm_we;
            r_miso_en       <= w_miso_en;
        end
    end

    assign bus.parallelLoad     = r_parallel_load;
    assign bus.addrWriteEnable  = r_addr_we;
    assign bus.dmWriteEnable    = r_dm_we;
    assign bus.misoBufferEnable = r_miso_en;

`ifdef SPI_CTRL_ABORT_FLAG_EN
    logic r_count_nonzero;
    logic r_aborted;
    logic w_aborted;

    // tracks whether the bit counter currently holds a nonzero count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count_nonzero <= 1'b0;
        end else if (w_count_clear) begin
            r_count_nonzero <= 1'b0;
        end else if (w_count_inc) begin
            r_count_nonzero <= 1'b1;
        end
    end

    // CS rising after a transfer has made progress but before it completed
    always_comb begin
        w_aborted = 1'b0;
        if (bus.chipSelect) begin
            case (r_state)
                GET_ADDR, READ_SHIFT, WRITE_GET: w_aborted = r_count_nonzero;
                DECIDE, READ_LOAD, WRITE_STORE:  w_aborted = 1'b1;
                default:                         w_aborted = 1'b0;
            endcase
        end
    end

    // one-clk abort pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_aborted <= 1'b0;
        end else begin
            r_aborted <= w_aborted;
        end
    end

    assign bus.transferAborted = r_aborted;
`endif

endmodule

// File: tb/tb_spi_controller.sv
// Testbench for spi_controller: directed transaction table, hand-written
// reset sequence, and randomized transactions against a timestamp model.
module tb_spi_controller;
    import spi_pkg::*;

    localparam int S      = 8;   // clk cycles between SCLK edge pulses
    localparam int N_RAND = 20;

    logic clk = 1'b0;
    logic reset;

    spi_controller_if u_if ();

    spi_controller #(
        .WIDTH (SPI_WIDTH)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [3:0] obs;   // {addrWriteEnable, parallelLoad, dmWriteEnable, misoBufferEnable}
    logic       obs_ab;
    int n_awe, n_pl, n_dwe, n_miso, n_abort;

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        int         n_pulses;
        logic       cs_last;
        int         e_awe;
        int         e_pl;
        int         e_dwe;
        int         e_miso;
        int         e_abort;
    } vec_t;

    vec_t vecs [9];

    logic cq [$];
    logic pq [$];
    logic wq [$];
    int   xq [$];
    logic aq [$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // apply one cycle of inputs, sample outputs just after the edge
    task automatic step(input logic cs, input logic pe, input logic rw);
        u_if.chipSelect        = cs;
        u_if.peripheralClkEdge = pe;
        u_if.rwBit             = rw;
        @(posedge clk);
        #1;
        obs = {u_if.addrWriteEnable, u_if.parallelLoad, u_if.dmWriteEnable, u_if.misoBufferEnable};
`ifdef SPI_CTRL_ABORT_FLAG_EN
        obs_ab = u_if.transferAborted;
`else
        obs_ab = 1'b0;
`endif
        n_awe   += int'(obs[3]);
        n_pl    += int'(obs[2]);
        n_dwe   += int'(obs[1]);
        n_miso  += int'(obs[0]);
        n_abort += int'(obs_ab);
    endtask

    task automatic clear_counts();
        n_awe = 0; n_pl = 0; n_dwe = 0; n_miso = 0; n_abort = 0;
    endtask

    // n pulses spaced S clks apart with CS held low
    task automatic pulses(input int n, input logic rw);
        for (int k = 0; k < n; k++) begin
            for (int g = 0; g < S - 1; g++) step(1'b0, 1'b0, rw);
            step(1'b0, 1'b1, rw);
        end
    endtask

    // one directed transaction; rwBit follows an MSB-first shift register
    task automatic run_txn(input logic rw, input logic [6:0] addr, input int n_pulses, input logic cs_last);
        logic [7:0] abyte;
        logic [7:0] sr;
        logic       cs_now;
        logic       bit_in;
        abyte  = {addr, rw};
        sr     = 8'h00;
        cs_now = 1'b0;
        clear_counts();
        step(1'b0, 1'b0, sr[0]);
        for (int k = 1; k <= n_pulses; k++) begin
            for (int g = 0; g < S - 1; g++) step(1'b0, 1'b0, sr[0]);
            if (k <= 8) bit_in = abyte[8 - k];
            else        bit_in = 1'($urandom);
            cs_now = cs_last && (k == n_pulses);
            step(cs_now, 1'b1, sr[0]);
            sr = {sr[6:0], bit_in};
        end
        if (!cs_now) for (int g = 0; g < 10; g++) step(1'b0, 1'b0, sr[0]);
        for (int g = 0; g < 3; g++) step(1'b1, 1'b0, sr[0]);
    endtask

    task automatic gen(input logic c, input logic p);
        cq.push_back(c);
        pq.push_back(p);
        wq.push_back(1'($urandom));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   n, f, e, a, b, cnt, dcnt, np, gap, tl;
        logic rd, cl, ended, ab;

        // rw, addr, pulses, cs_last | awe, pl, dwe, miso cycles, abort
        vecs[0] = '{1'b0, 7'h15, 16, 1'b0, 1, 0, 1,  0, 0};  // plain write to 0x15
        vecs[1] = '{1'b1, 7'h2A, 16, 1'b0, 1, 1, 0, 62, 0};  // plain read
        vecs[2] = '{1'b0, 7'h15,  5, 1'b0, 0, 0, 0,  0, 1};  // CS up after 5 address pulses
        vecs[3] = '{1'b0, 7'h15, 16, 1'b1, 1, 0, 0,  0, 1};  // CS up with 8th data pulse
        vecs[4] = '{1'b0, 7'h33, 28, 1'b0, 1, 0, 1,  0, 0};  // 12 extra pulses in DONE
        vecs[5] = '{1'b1, 7'h7F, 11, 1'b1, 1, 1, 0, 22, 1};  // read cut after 3 data pulses
        vecs[6] = '{1'b1, 7'h00,  0, 1'b0, 0, 0, 0,  0, 0};  // CS window with no pulses
        vecs[7] = '{1'b1, 7'h01,  8, 1'b1, 0, 0, 0,  0, 1};  // CS up with 8th address pulse
        vecs[8] = '{1'b1, 7'h55, 24, 1'b0, 1, 1, 0, 62, 0};  // read with extras in DONE

        reset                  = 1'b1;
        u_if.chipSelect        = 1'b1;
        u_if.peripheralClkEdge = 1'b0;
        u_if.rwBit             = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset awe",  int'(u_if.addrWriteEnable),  0);
        check("reset pl",   int'(u_if.parallelLoad),     0);
        check("reset dwe",  int'(u_if.dmWriteEnable),    0);
        check("reset miso", int'(u_if.misoBufferEnable), 0);
`ifdef SPI_CTRL_ABORT_FLAG_EN
        check("reset abort", int'(u_if.transferAborted), 0);
`endif
        reset = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);

        // directed table
        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i].rw, vecs[i].addr, vecs[i].n_pulses, vecs[i].cs_last);
            check($sformatf("vec%0d awe", i),  n_awe,  vecs[i].e_awe);
            check($sformatf("vec%0d pl", i),   n_pl,   vecs[i].e_pl);
            check($sformatf("vec%0d dwe", i),  n_dwe,  vecs[i].e_dwe);
            check($sformatf("vec%0d miso", i), n_miso, vecs[i].e_miso);
`ifdef SPI_CTRL_ABORT_FLAG_EN
            check($sformatf("vec%0d abort", i), n_abort, vecs[i].e_abort);
`endif
        end

        // reset in the middle of a read data phase
        step(1'b0, 1'b0, 1'b1);
        pulses(8, 1'b1);
        pulses(3, 1'b1);
        check("mid-read miso", int'(obs[0]), 1);
        #2;
        reset = 1'b1;
        #1;
        check("async reset outs", int'({u_if.addrWriteEnable, u_if.parallelLoad,
                                         u_if.dmWriteEnable, u_if.misoBufferEnable}), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_counts();
        step(1'b0, 1'b0, 1'b0);
        pulses(16, 1'b0);
        for (int g = 0; g < 4; g++) step(1'b0, 1'b0, 1'b0);
        for (int g = 0; g < 3; g++) step(1'b1, 1'b0, 1'b0);
        check("post-reset awe",  n_awe,  1);
        check("post-reset pl",   n_pl,   0);
        check("post-reset dwe",  n_dwe,  1);
        check("post-reset miso", n_miso, 0);
`ifdef SPI_CTRL_ABORT_FLAG_EN
        check("post-reset abort", n_abort, 0);
`endif

        // randomized transactions against a pulse-timestamp model
        for (int r = 0; r < N_RAND; r++) begin
            cq.delete(); pq.delete(); wq.delete(); xq.delete(); aq.delete();
            gen(1'b1, 1'($urandom));
            gen(1'b1, 1'($urandom));
            gen(1'b0, ($urandom_range(0, 3) == 0));
            np    = int'($urandom_range(0, 22));
            cl    = 1'($urandom);
            ended = 1'b0;
            for (int k = 1; k <= np; k++) begin
                gap = int'($urandom_range(S - 1, S + 3));
                for (int g = 0; g < gap; g++) gen(1'b0, 1'b0);
                ended = cl && (k == np);
                gen(ended, 1'b1);
            end
            if (!ended) begin
                tl = int'($urandom_range(1, 10));
                for (int g = 0; g < tl; g++) gen(1'b0, 1'b0);
            end
            for (int g = 0; g < 3; g++) gen(1'b1, 1'($urandom));

            // expected outputs from pulse timestamps
            n = cq.size();
            for (int t = 0; t < n; t++) begin
                xq.push_back(0);
                aq.push_back(1'b0);
            end
            f = 2;
            e = -1;
            for (int t = f + 1; t < n; t++) if (cq[t] && e < 0) e = t;
            a = -1; b = -1; cnt = 0; dcnt = 0; rd = 1'b0;
            for (int t = f + 1; t < e && a < 0; t++) begin
                if (pq[t]) begin
                    cnt++;
                    if (cnt == 8) a = t;
                end
            end
            if (a >= 0) begin
                xq[a] = xq[a] | 8;
                rd = wq[a + 1];
                if (rd && (a + 1 < e)) xq[a + 1] = xq[a + 1] | 4;
                for (int t = (rd ? a + 3 : a + 2); t < e && b < 0; t++) begin
                    if (pq[t]) begin
                        dcnt++;
                        if (dcnt == 8) b = t;
                    end
                end
                if (rd) begin
                    for (int t = a + 2; t < ((b >= 0) ? b : e); t++) xq[t] = xq[t] | 1;
                end else if (b >= 0) begin
                    xq[b] = xq[b] | 2;
                end
            end
            if (a < 0)                      ab = (cnt > 0);
            else if (e == a + 1)            ab = 1'b1;
            else if (rd && (e == a + 2))    ab = 1'b1;
            else if (b < 0)                 ab = (dcnt > 0);
            else if (!rd && (e == b + 1))   ab = 1'b1;
            else                            ab = 1'b0;
            aq[e] = ab;

            clear_counts();
            for (int t = 0; t < n; t++) begin
                step(cq[t], pq[t], wq[t]);
                check($sformatf("rand%0d cyc%0d outs", r, t), int'(obs), xq[t]);
`ifdef SPI_CTRL_ABORT_FLAG_EN
                check($sformatf("rand%0d cyc%0d abort", r, t), int'(obs_ab), int'(aq[t]));
`endif
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
